// File: rtl/ysyx_040750_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_040750_pipe_ctrl
//
// Hazard and sequencing controller for the IF/ID pipeline register.
//   - Detects load-use hazards between the EX load and the ID sources and
//     holds ID (O_IF_ID_stall), counting every stalled cycle.
//   - Turns the next latched fetch into a bubble after a taken jump, keeping
//     the request pending until IF/ID actually accepts a fetch.
//   - Delivers each timer interrupt exactly once, tagging a real fetch and
//     re-arming if that tagged instruction is flushed by a later jump.
//
// Ports
//   I_sys_clk        clock, rising edge
//   I_rst            synchronous, active-high reset
//   I_ID_rs1/_rs2    ID source register indices
//   I_ID_rs1_en/_rs2_en  ID source actually read
//   I_ID_valid       IF/ID holds a valid instruction
//   I_ID_bubble      ID instruction is an injected bubble
//   I_EX_valid       EX holds a valid instruction
//   I_EX_load        EX instruction is a load
//   I_EX_rd          EX destination register
//   I_EX_jmp         EX resolved a taken branch/jump (pulse)
//   I_IF_valid       fetch data valid toward IF/ID
//   I_IF_ID_allowin  IF/ID can accept
//   I_timer_req      level timer interrupt request
//   I_trap_ack       WB committed the interrupt trap (pulse)
//   O_IF_ID_stall    hold ID (load-use), combinational
//   O_IF_ID_jmp      bubble the next latched fetch
//   O_timer_intr     tag the next latched fetch with the interrupt
//   O_ID_timer_intr  force bubbles into IF/ID while interrupt in flight
//   O_stall_cnt      wrapping count of stalled cycles
//
// Interrupt FSM
//   state  | meaning
//   IDLE   | no interrupt pending, waiting for I_timer_req
//   ARM    | interrupt pending, waiting for a clean accepted fetch to tag
//   INJ    | tag just latched into IF/ID, bubbles forced behind it
//   WAIT   | tagged instruction in flight, waiting for the trap commit
// ---------------------------------------------------------------------------
module ysyx_040750_pipe_ctrl (
  input  logic        I_sys_clk,
  input  logic        I_rst,
  input  logic [4:0]  I_ID_rs1,
  input  logic [4:0]  I_ID_rs2,
  input  logic        I_ID_rs1_en,
  input  logic        I_ID_rs2_en,
  input  logic        I_ID_valid,
  input  logic        I_ID_bubble,
  input  logic        I_EX_valid,
  input  logic        I_EX_load,
  input  logic [4:0]  I_EX_rd,
  input  logic        I_EX_jmp,
  input  logic        I_IF_valid,
  input  logic        I_IF_ID_allowin,
  input  logic        I_timer_req,
  input  logic        I_trap_ack,
  output logic        O_IF_ID_stall,
  output logic        O_IF_ID_jmp,
  output logic        O_timer_intr,
  output logic        O_ID_timer_intr,
  output logic [31:0] O_stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_INJ  = 2'd2,
    S_WAIT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        jmp_pend_q, jmp_pend_d;
  logic        id_timer_intr_q, id_timer_intr_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic        rs1_hit;
  logic        rs2_hit;
  logic        ex_load_live;
  logic        hz;
  logic        acc;
  logic        jmp;
  logic        tag;

  // Hazard detection. x0 is never a real dependency, and a bubble in ID
  // reads nothing, so neither may stall.
  assign rs1_hit      = I_ID_rs1_en & (I_ID_rs1 == I_EX_rd);
  assign rs2_hit      = I_ID_rs2_en & (I_ID_rs2 == I_EX_rd);
  assign ex_load_live = I_EX_valid & I_EX_load & (I_EX_rd != 5'd0);
  assign hz           = ex_load_live & I_ID_valid & ~I_ID_bubble & (rs1_hit | rs2_hit);

  assign acc = I_IF_valid & I_IF_ID_allowin;

  // A jump seen while IF/ID cannot accept is remembered until the first
  // accepted fetch, which is the one that must become a bubble.
  assign jmp = I_EX_jmp | jmp_pend_q;

  always_comb begin
    jmp_pend_d = jmp_pend_q;
    if (acc) begin
      jmp_pend_d = 1'b0;
    end else if (jmp) begin
      jmp_pend_d = 1'b1;
    end
  end

  // Tag only a fetch that actually lands in IF/ID as a real instruction:
  // a flushed fetch or one held behind a load-use stall would lose it.
  assign tag = (state_q == S_ARM) & acc & ~jmp & ~hz;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (I_timer_req) begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (tag) begin
          state_d = S_INJ;
        end
      end
      S_INJ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A commit wins over a simultaneous jump: the trap already retired.
        if (I_trap_ack) begin
          state_d = S_IDLE;
        end else if (I_EX_jmp) begin
          state_d = S_ARM;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered so the bubble-forcing output is a clean flop, asserted the
  // cycle after the tag.
  assign id_timer_intr_d = (state_d == S_INJ) | (state_d == S_WAIT);

  assign stall_cnt_d = hz ? (stall_cnt_q + 32'd1) : stall_cnt_q;

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      state_q         <= S_IDLE;
      jmp_pend_q      <= 1'b0;
      id_timer_intr_q <= 1'b0;
      stall_cnt_q     <= 32'd0;
    end else begin
      state_q         <= state_d;
      jmp_pend_q      <= jmp_pend_d;
      id_timer_intr_q <= id_timer_intr_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign O_IF_ID_stall   = hz;
  assign O_IF_ID_jmp     = jmp;
  assign O_timer_intr    = tag;
  assign O_ID_timer_intr = id_timer_intr_q;
  assign O_stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_ysyx_040750_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_040750_pipe_ctrl. Each scenario is a table of per-cycle
// stimulus rows with hand-derived expected outputs. Inputs are driven at the
// falling edge; the expected outputs and stall count are pushed to a
// scoreboard queue and popped/compared 1 time unit later.
// Output vector order: {stall, jmp, timer_intr, id_timer_intr}.
// ---------------------------------------------------------------------------
module tb_ysyx_040750_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_rs1_en, id_rs2_en;
  logic        id_valid, id_bubble;
  logic        ex_valid, ex_load;
  logic [4:0]  ex_rd;
  logic        ex_jmp;
  logic        if_valid, allowin;
  logic        timer_req, trap_ack;
  logic        o_stall, o_jmp, o_tintr, o_idintr;
  logic [31:0] o_cnt;

  ysyx_040750_pipe_ctrl dut (
    .I_sys_clk       (clk),
    .I_rst           (rst),
    .I_ID_rs1        (id_rs1),
    .I_ID_rs2        (id_rs2),
    .I_ID_rs1_en     (id_rs1_en),
    .I_ID_rs2_en     (id_rs2_en),
    .I_ID_valid      (id_valid),
    .I_ID_bubble     (id_bubble),
    .I_EX_valid      (ex_valid),
    .I_EX_load       (ex_load),
    .I_EX_rd         (ex_rd),
    .I_EX_jmp        (ex_jmp),
    .I_IF_valid      (if_valid),
    .I_IF_ID_allowin (allowin),
    .I_timer_req     (timer_req),
    .I_trap_ack      (trap_ack),
    .O_IF_ID_stall   (o_stall),
    .O_IF_ID_jmp     (o_jmp),
    .O_timer_intr    (o_tintr),
    .O_ID_timer_intr (o_idintr),
    .O_stall_cnt     (o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode: 0 quiet, 1 hazard on rs1, 2 hazard on rs2, 3 rd=x0,
  //       4 rs1 match but not read, 5 match but ID is a bubble, 6 EX not a load
  typedef struct packed {
    bit       rst;
    bit [2:0] mode;
    bit       jmp;
    bit       ifv;
    bit       allow;
    bit       treq;
    bit       ack;
    bit [3:0] exp;
  } row_t;

  typedef struct {
    logic [3:0]  outs;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_cnt  = 32'd0;

  function automatic row_t mk(input bit r, input bit [2:0] m, input bit j,
                              input bit iv, input bit al, input bit tq,
                              input bit ak, input bit [3:0] e);
    row_t x;
    x = '{r, m, j, iv, al, tq, ak, e};
    return x;
  endfunction

  task automatic apply_row(input row_t r);
    rst       = r.rst;
    ex_jmp    = r.jmp;
    if_valid  = r.ifv;
    allowin   = r.allow;
    timer_req = r.treq;
    trap_ack  = r.ack;
    ex_valid  = 1'b0; ex_load = 1'b0; ex_rd = 5'd0;
    id_valid  = 1'b0; id_bubble = 1'b0;
    id_rs1    = 5'd0; id_rs2 = 5'd0; id_rs1_en = 1'b0; id_rs2_en = 1'b0;
    if (r.mode != 3'd0) begin
      ex_valid = 1'b1; ex_load = 1'b1; ex_rd = 5'd5; id_valid = 1'b1;
    end
    case (r.mode)
      3'd1: begin id_rs1 = 5'd5; id_rs1_en = 1'b1; end
      3'd2: begin id_rs1 = 5'd3; id_rs1_en = 1'b1; id_rs2 = 5'd5; id_rs2_en = 1'b1; end
      3'd3: begin ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_en = 1'b1; end
      3'd4: begin id_rs1 = 5'd5; id_rs1_en = 1'b0; end
      3'd5: begin id_rs1 = 5'd5; id_rs1_en = 1'b1; id_bubble = 1'b1; end
      3'd6: begin ex_load = 1'b0; id_rs1 = 5'd5; id_rs1_en = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    row_t tbl[$];
    exp_t e;
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 4'b1100));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'b0000));
    foreach (tbl[i]) begin
      @(negedge clk);
      apply_row(tbl[i]);
      sbq.push_back('{outs: tbl[i].exp, cnt: exp_cnt});
      #1;
      e = sbq.pop_front();
      n_checks++;
      if ({o_stall, o_jmp, o_tintr, o_idintr} !== e.outs) begin
        n_fail++;
        $display("FAIL reset[%0d] outs got=%b exp=%b", i, {o_stall, o_jmp, o_tintr, o_idintr}, e.outs);
      end
      n_checks++;
      if (o_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL reset[%0d] stall_cnt got=%h exp=%h", i, o_cnt, e.cnt);
      end
      exp_cnt = tbl[i].rst ? 32'd0 : exp_cnt + {31'd0, e.outs[3]};
    end
  endtask

  task automatic test_load_use();
    row_t tbl[$];
    exp_t e;
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4'b1000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 4, 0, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 6, 0, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 4'b1000));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 4'b1000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'b0000));
    foreach (tbl[i]) begin
      @(negedge clk);
      apply_row(tbl[i]);
      sbq.push_back('{outs: tbl[i].exp, cnt: exp_cnt});
      #1;
      e = sbq.pop_front();
      n_checks++;
      if ({o_stall, o_jmp, o_tintr, o_idintr} !== e.outs) begin
        n_fail++;
        $display("FAIL load_use[%0d] outs got=%b exp=%b", i, {o_stall, o_jmp, o_tintr, o_idintr}, e.outs);
      end
      n_checks++;
      if (o_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL load_use[%0d] stall_cnt got=%h exp=%h", i, o_cnt, e.cnt);
      end
      exp_cnt = tbl[i].rst ? 32'd0 : exp_cnt + {31'd0, e.outs[3]};
    end
  endtask

  task automatic test_flush();
    row_t tbl[$];
    exp_t e;
    // jump with no accept for two cycles, then accept
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 4'b0100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'b0100));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'b0100));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'b0000));
    // jump coinciding with accept lasts one cycle
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 4'b0100));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'b0000));
    // second jump while pending; allowin without valid is not an accept
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4'b0100));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4'b0100));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 4'b0100));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'b0100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'b0000));
    foreach (tbl[i]) begin
      @(negedge clk);
      apply_row(tbl[i]);
      sbq.push_back('{outs: tbl[i].exp, cnt: exp_cnt});
      #1;
      e = sbq.pop_front();
      n_checks++;
      if ({o_stall, o_jmp, o_tintr, o_idintr} !== e.outs) begin
        n_fail++;
        $display("FAIL flush[%0d] outs got=%b exp=%b", i, {o_stall, o_jmp, o_tintr, o_idintr}, e.outs);
      end
      n_checks++;
      if (o_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL flush[%0d] stall_cnt got=%h exp=%h", i, o_cnt, e.cnt);
      end
      exp_cnt = tbl[i].rst ? 32'd0 : exp_cnt + {31'd0, e.outs[3]};
    end
  endtask

  task automatic test_intr_happy();
    row_t tbl[$];
    exp_t e;
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 4'b0010));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 4'b0001));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 4'b0001));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 4'b0001));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 4'b0001));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'b0000));
    foreach (tbl[i]) begin
      @(negedge clk);
      apply_row(tbl[i]);
      sbq.push_back('{outs: tbl[i].exp, cnt: exp_cnt});
      #1;
      e = sbq.pop_front();
      n_checks++;
      if ({o_stall, o_jmp, o_tintr, o_idintr} !== e.outs) begin
        n_fail++;
        $display("FAIL intr_happy[%0d] outs got=%b exp=%b", i, {o_stall, o_jmp, o_tintr, o_idintr}, e.outs);
      end
      n_checks++;
      if (o_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL intr_happy[%0d] stall_cnt got=%h exp=%h", i, o_cnt, e.cnt);
      end
      exp_cnt = tbl[i].rst ? 32'd0 : exp_cnt + {31'd0, e.outs[3]};
    end
  endtask

  task automatic test_intr_vs_flush();
    row_t tbl[$];
    exp_t e;
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4'b0000)); // IDLE -> ARM
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 4'b0000)); // ARM, no accept
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 4'b0100)); // ARM, jump suppresses tag
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'b0010)); // tag
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'b0001)); // INJ
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4'b0101)); // WAIT, jump -> ARM
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'b0100)); // ARM, pending flush
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 4'b1000)); // ARM, load-use blocks tag
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'b0010)); // re-tag
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'b0001)); // INJ
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'b0001)); // WAIT, commit
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'b0000)); // IDLE
    foreach (tbl[i]) begin
      @(negedge clk);
      apply_row(tbl[i]);
      sbq.push_back('{outs: tbl[i].exp, cnt: exp_cnt});
      #1;
      e = sbq.pop_front();
      n_checks++;
      if ({o_stall, o_jmp, o_tintr, o_idintr} !== e.outs) begin
        n_fail++;
        $display("FAIL intr_vs_flush[%0d] outs got=%b exp=%b", i, {o_stall, o_jmp, o_tintr, o_idintr}, e.outs);
      end
      n_checks++;
      if (o_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL intr_vs_flush[%0d] stall_cnt got=%h exp=%h", i, o_cnt, e.cnt);
      end
      exp_cnt = tbl[i].rst ? 32'd0 : exp_cnt + {31'd0, e.outs[3]};
    end
  endtask

  task automatic test_cnt_wrap();
    row_t tbl[$];
    exp_t e;
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4'b1000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'b0000));
    foreach (tbl[i]) begin
      @(negedge clk);
      apply_row(tbl[i]);
      sbq.push_back('{outs: tbl[i].exp, cnt: exp_cnt});
      #1;
      e = sbq.pop_front();
      n_checks++;
      if ({o_stall, o_jmp, o_tintr, o_idintr} !== e.outs) begin
        n_fail++;
        $display("FAIL cnt_wrap[%0d] outs got=%b exp=%b", i, {o_stall, o_jmp, o_tintr, o_idintr}, e.outs);
      end
      n_checks++;
      if (o_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL cnt_wrap[%0d] stall_cnt got=%h exp=%h", i, o_cnt, e.cnt);
      end
      exp_cnt = tbl[i].rst ? 32'd0 : exp_cnt + {31'd0, e.outs[3]};
    end
  endtask

  task automatic test_reset_midop();
    row_t tbl[$];
    exp_t e;
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4'b0000)); // IDLE -> ARM
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'b0010)); // tag
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 4'b1101)); // INJ, jump pending, stall
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'b0101)); // WAIT + pending, reset
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'b0000)); // IDLE, nothing pending
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'b0000));
    foreach (tbl[i]) begin
      @(negedge clk);
      apply_row(tbl[i]);
      sbq.push_back('{outs: tbl[i].exp, cnt: exp_cnt});
      #1;
      e = sbq.pop_front();
      n_checks++;
      if ({o_stall, o_jmp, o_tintr, o_idintr} !== e.outs) begin
        n_fail++;
        $display("FAIL reset_midop[%0d] outs got=%b exp=%b", i, {o_stall, o_jmp, o_tintr, o_idintr}, e.outs);
      end
      n_checks++;
      if (o_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL reset_midop[%0d] stall_cnt got=%h exp=%h", i, o_cnt, e.cnt);
      end
      exp_cnt = tbl[i].rst ? 32'd0 : exp_cnt + {31'd0, e.outs[3]};
    end
  endtask

  initial begin
    apply_row(mk(1, 0, 0, 0, 0, 0, 0, 4'b0000));
    repeat (2) @(posedge clk);
    test_reset();
    test_load_use();
    test_flush();
    test_intr_happy();
    test_intr_vs_flush();
    test_cnt_wrap();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
